// File: rtl/pipe_reg_chain.sv
// pipe_reg_chain: STAGES-deep stallable register chain with bubble collapse and flush.
// Optional macro PIPE_REG_CLEAR_DATA_EN forces data to RESET_VAL in every empty or flushed stage.
module pipe_reg_chain #(
  parameter int unsigned        WIDTH     = 32,
  parameter int unsigned        STAGES    = 2,
  parameter logic [WIDTH-1:0]   RESET_VAL = '0,
  localparam int unsigned       OCC_W     = $clog2(STAGES + 1)
) (
  input  logic             clk,
  input  logic             clr,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] in_data,
  output logic             in_ready,
  input  logic             stall,
  input  logic             flush,
  output logic             out_valid,
  output logic [WIDTH-1:0] out_data,
  output logic [OCC_W-1:0] occupancy
);

  logic [STAGES-1:0] r_valid;
  logic [WIDTH-1:0]  r_data [STAGES];
  logic [OCC_W-1:0]  r_occ;

  logic [STAGES-1:0] w_adv;
  logic [STAGES-1:0] w_src_valid;
  logic [WIDTH-1:0]  w_src_data [STAGES];
  logic              w_accept;
  logic              w_deliver;

  // Stage k may move iff some stage at or downstream of k is empty, or the output drains.
  // Written in closed form so no bit of w_adv depends on another bit of itself.
  for (genvar g = 0; g < STAGES; g++) begin : g_adv
    assign w_adv[g] = !stall || !(&r_valid[STAGES-1:g]);
  end

  // NOTE: every always_comb output gets a default first so no latch is inferred.
  always_comb begin
    w_src_valid    = '0;
    w_src_valid[0] = in_valid;
    for (int k = 0; k < STAGES; k++) w_src_data[k] = in_data;
    for (int k = 1; k < STAGES; k++) begin
      w_src_valid[k] = r_valid[k-1];
      w_src_data[k]  = r_data[k-1];
    end
  end

  assign w_accept  = in_valid && w_adv[0];
  assign w_deliver = r_valid[STAGES-1] && !stall;

  // NOTE: sequential state uses non-blocking assignments only, so every stage samples pre-edge values.
  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      r_valid <= '0;
      r_occ   <= '0;
    end else if (flush) begin
      r_valid <= '0;
      r_occ   <= '0;
    end else begin
      r_valid <= (w_adv & w_src_valid) | (~w_adv & r_valid);
      r_occ   <= r_occ + OCC_W'(w_accept) - OCC_W'(w_deliver);
    end
  end

  // NOTE: the stage data array is flops, not RAM, so it takes the async reset like any register.
  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      for (int k = 0; k < STAGES; k++) r_data[k] <= RESET_VAL;
    end else begin
      for (int k = 0; k < STAGES; k++) begin
`ifdef PIPE_REG_CLEAR_DATA_EN
        if (flush)
          r_data[k] <= RESET_VAL;
        else if (w_adv[k])
          r_data[k] <= w_src_valid[k] ? w_src_data[k] : RESET_VAL;
`else
        if (w_adv[k])
          r_data[k] <= w_src_data[k];
`endif
      end
    end
  end

  assign in_ready  = w_adv[0];
  assign out_valid = r_valid[STAGES-1];
  assign out_data  = r_data[STAGES-1];
  assign occupancy = r_occ;

endmodule

// File: doc/pipe_reg_chain.md
Name: pipe_reg_chain

Overview:
- Parametrised multi-stage pipeline register chain, WIDTH bits wide and STAGES deep.
- Each stage carries a data word and a valid bit.
- Supports downstream back-pressure (stall), synchronous flush, and bubble collapse: empty stages advance even while the output is stalled.
- Used between CPU pipeline stages and on other datapath crossings that need registered, stallable transport.

Parameters:
- WIDTH, 32, data bits per stage.
- STAGES, 2, number of register stages (>=1). Latency with no stall = STAGES cycles.
- RESET_VAL, 0, data value loaded into every stage on clr.

Ports:
- clk  input  1  clock, all state updates on posedge.
- clr  input  1  asynchronous active-high reset.
- in_valid  input  1  upstream presents a word this cycle.
- in_data  input  WIDTH  upstream data word.
- in_ready  output  1  chain can accept a word this cycle (combinational).
- stall  input  1  downstream not accepting; last stage must hold.
- flush  input  1  synchronous discard of all in-flight words.
- out_valid  output  1  valid bit of last stage.
- out_data  output  WIDTH  data of last stage.
- occupancy  output  $clog2(STAGES+1)  registered count of valid stages.

Behaviour:
- Reset: clr is asynchronous and active-high; clk is the clock. While clr is high, all state is reset:
  - all valid bits = 0, all stage data = RESET_VAL;
  - out_valid = 0, out_data = RESET_VAL, occupancy = 0;
  - in_ready = 1 (derived combinationally).
- Reset mid-operation: in-flight words are lost. No output glitches to stale data after clr deasserts.
- Stage indexing: stage 0 is the input side, stage STAGES-1 drives out_*.
- Advance rules, evaluated combinationally each cycle:
  - adv[STAGES-1] = !stall || !valid[STAGES-1].
  - adv[k] = !valid[k] || adv[k+1], for k < STAGES-1.
  - in_ready = adv[0].
- Register update when adv[k] is true: stage k loads from stage k-1 (or in_data/in_valid for k=0), both data and valid.
- Register update when adv[k] is false: stage k holds data and valid.
- Handshake:
  - A word is accepted iff in_valid && in_ready at posedge.
  - A word is delivered iff out_valid && !stall at posedge.
  - in_valid with in_ready=0: not captured. Upstream must hold the word.
- Bubble collapse: with stall=1 and out_valid=1, invalid stages upstream still fill. The chain absorbs up to STAGES words total before in_ready drops.
- Full condition: all STAGES valid and stall=1 -> in_ready=0.
- Empty condition: occupancy=0, out_valid=0, in_ready=1 regardless of stall.
- Flush:
  - Next cycle all valid bits = 0 and occupancy = 0.
  - Priority over stall and over the input: a word presented with flush=1 is dropped even if in_ready=1.
  - in_ready is not gated by flush.
  - Data registers follow the Optional Feature rule.
- occupancy: registered. Next value = current + accepted - delivered, or 0 on flush. Never exceeds STAGES.
- STAGES=1: degenerates to a single stallable register. in_ready = !stall || !out_valid.
- Data is never modified; there is no arithmetic on the data path.

Optional Feature:
- Macro: PIPE_REG_CLEAR_DATA_EN.
- Defined:
  - On flush, every stage data register loads RESET_VAL.
  - When a stage loads an invalid slot (valid=0), its data loads RESET_VAL instead of the incoming data.
  - out_data therefore equals RESET_VAL whenever out_valid=0 (after the first clock following reset).
- Undefined:
  - Data registers load unconditionally on advance; flush clears only valid bits.
  - out_data is don't-care when out_valid=0.
  - Saves WIDTH*STAGES mux inputs.

Test Plan:
- Reset (WIDTH=32, STAGES=3, RESET_VAL=32'hDEAD_BEEF): pulse clr mid-stream with 2 words in flight -> out_valid=0, out_data=DEADBEEF, occupancy=0 immediately, in_ready=1 while clr is high.
- Latency (STAGES=3, stall=0): input 0x11, 0x22, 0x33 on consecutive cycles -> outputs appear 3 cycles after each input, in order, with occupancy holding at 3 during steady state.
- Bubble collapse (STAGES=3): send 0xA1, idle 2 cycles, send 0xA2, 0xA3 with stall=1 from when 0xA1 reaches output -> occupancy reaches 3, in_ready=0. Release stall -> delivery order A1, A2, A3 with no duplicate or lost word.
- Back-pressure hold: full chain, stall=1, in_valid=1 with 0x44 held 4 cycles -> 0x44 not accepted until first delivery cycle, then accepted exactly once.
- Flush priority: occupancy=2, flush=1 with stall=1 and in_valid=1 (0x55) -> next cycle occupancy=0 and out_valid=0, and 0x55 never appears. With PIPE_REG_CLEAR_DATA_EN, out_data=RESET_VAL.
- STAGES=1: alternate stall 1/0 with a continuous stream 0x01..0x08 -> exactly 8 deliveries in order, in_ready low only on cycles with stall=1 && out_valid=1.
